// File: rtl/controller_pkg.sv
// Shared decode constants for the RV32I controller: mux selects, ALU ops,
// load/store encodings, opcodes and the funct3 -> ALU op mapping.
package ctrl_pkg;

  localparam int IMM_TYPE_WIDTH = 3;
  localparam int ALUOP_WIDTH    = 4;

  localparam logic PC_PLUS_4 = 1'b0;
  localparam logic PC_ALU    = 1'b1;
  localparam logic A_REG     = 1'b0;
  localparam logic A_PC      = 1'b1;
  localparam logic B_REG     = 1'b0;
  localparam logic B_IMM     = 1'b1;

  localparam logic [IMM_TYPE_WIDTH-1:0] IMM_I = 3'd0;
  localparam logic [IMM_TYPE_WIDTH-1:0] IMM_S = 3'd1;
  localparam logic [IMM_TYPE_WIDTH-1:0] IMM_B = 3'd2;
  localparam logic [IMM_TYPE_WIDTH-1:0] IMM_U = 3'd3;
  localparam logic [IMM_TYPE_WIDTH-1:0] IMM_J = 3'd4;

  localparam logic [ALUOP_WIDTH-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALUOP_WIDTH-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALUOP_WIDTH-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALUOP_WIDTH-1:0] ALU_SLT  = 4'd3;
  localparam logic [ALUOP_WIDTH-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALUOP_WIDTH-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALUOP_WIDTH-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALUOP_WIDTH-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALUOP_WIDTH-1:0] ALU_OR   = 4'd8;
  localparam logic [ALUOP_WIDTH-1:0] ALU_AND  = 4'd9;
  localparam logic [ALUOP_WIDTH-1:0] ALU_B    = 4'd10;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  localparam logic [2:0] LD_BYTE  = 3'b000;
  localparam logic [2:0] LD_HALF  = 3'b001;
  localparam logic [2:0] LD_WORD  = 3'b010;
  localparam logic [2:0] LD_BYTEU = 3'b100;
  localparam logic [2:0] LD_HALFU = 3'b101;

  localparam logic [3:0] STR_BYTE = 4'b0001;
  localparam logic [3:0] STR_HALF = 4'b0011;
  localparam logic [3:0] STR_WORD = 4'b1111;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // alt is funct7[5] already qualified by the caller (OP-IMM only passes it for shifts)
  function automatic logic [ALUOP_WIDTH-1:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/controller_branch_resolve.sv
// Branch resolution: funct3 plus comparator flags -> taken, and compare signedness.
module branch_resolve (
  input  logic [2:0] funct3,
  input  logic       br_eq,
  input  logic       br_lt,
  output logic       taken,
  output logic       br_un
);

  assign br_un = funct3[1];

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:         taken = br_eq;
      3'b001:         taken = ~br_eq;
      3'b100, 3'b110: taken = br_lt;
      3'b101, 3'b111: taken = ~br_lt;
      default:        taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/controller.sv
// Single-cycle RV32I decode/control unit with a registered illegal-opcode flag.
// Build option: CTRL_ILLEGAL_STICKY_EN makes `illegal` hold until reset.
module controller
  import ctrl_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DWIDTH-1:0]         instr,
  input  logic                      br_eq,
  input  logic                      br_lt,
  output logic                      pc_sel,
  output logic [IMM_TYPE_WIDTH-1:0] imm_sel,
  output logic                      rf_we,
  output logic                      br_un,
  output logic                      a_sel,
  output logic                      b_sel,
  output logic [ALUOP_WIDTH-1:0]    alu_sel,
  output logic [DWIDTH/8-1:0]       dmem_wbe,
  output logic [2:0]                ld_sel,
  output logic [1:0]                wb_sel,
  output logic                      illegal
);

  localparam int WBE_W = DWIDTH / 8;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic             br_taken;
  logic             br_unsigned;
  logic             pc_sel_dec;
  logic             rf_we_dec;
  logic [WBE_W-1:0] wbe_dec;
  logic             illegal_event;
  logic             unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7_5     = instr[30];
  assign unused_instr = ^instr;

  branch_resolve u_branch_resolve (
    .funct3 (funct3),
    .br_eq  (br_eq),
    .br_lt  (br_lt),
    .taken  (br_taken),
    .br_un  (br_unsigned)
  );

  always_comb begin
    pc_sel_dec    = PC_PLUS_4;
    rf_we_dec     = 1'b0;
    wbe_dec       = '0;
    a_sel         = A_REG;
    b_sel         = B_IMM;
    alu_sel       = ALU_ADD;
    imm_sel       = IMM_I;
    wb_sel        = WB_ALU;
    br_un         = 1'b0;
    ld_sel        = funct3;
    illegal_event = 1'b0;
    case (opcode)
      OPC_LUI: begin
        imm_sel   = IMM_U;
        alu_sel   = ALU_B;
        rf_we_dec = 1'b1;
      end
      OPC_AUIPC: begin
        imm_sel   = IMM_U;
        a_sel     = A_PC;
        rf_we_dec = 1'b1;
      end
      OPC_JAL: begin
        imm_sel    = IMM_J;
        a_sel      = A_PC;
        pc_sel_dec = PC_ALU;
        rf_we_dec  = 1'b1;
        wb_sel     = WB_PC;
      end
      OPC_JALR: begin
        pc_sel_dec = PC_ALU;
        rf_we_dec  = 1'b1;
        wb_sel     = WB_PC;
      end
      OPC_BRANCH: begin
        imm_sel    = IMM_B;
        a_sel      = A_PC;
        br_un      = br_unsigned;
        pc_sel_dec = br_taken ? PC_ALU : PC_PLUS_4;
      end
      OPC_LOAD: begin
        rf_we_dec = 1'b1;
        wb_sel    = WB_MEM;
      end
      OPC_STORE: begin
        imm_sel = IMM_S;
        case (funct3)
          3'b000:  wbe_dec = WBE_W'(STR_BYTE);
          3'b001:  wbe_dec = WBE_W'(STR_HALF);
          3'b010:  wbe_dec = WBE_W'(STR_WORD);
          default: wbe_dec = '0;
        endcase
      end
      OPC_OP: begin
        b_sel     = B_REG;
        alu_sel   = alu_from_funct3(funct3, funct7_5);
        rf_we_dec = 1'b1;
      end
      OPC_OPIMM: begin
        // Only the right shift honours funct7[5]; bit 30 of an ADDI immediate is data.
        alu_sel   = alu_from_funct3(funct3, funct7_5 && (funct3 == 3'b101));
        rf_we_dec = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: illegal_event = 1'b1;
    endcase
  end

  // Architectural side effects are suppressed while reset is held.
  assign pc_sel   = rst ? PC_PLUS_4 : pc_sel_dec;
  assign rf_we    = rst ? 1'b0 : rf_we_dec;
  assign dmem_wbe = rst ? '0 : wbe_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal <= 1'b0;
    end else begin
`ifdef CTRL_ILLEGAL_STICKY_EN
      illegal <= illegal | illegal_event;
`else
      illegal <= illegal_event;
`endif
    end
  end

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: directed test-plan vectors plus random
// instructions checked against a behavioural decode model.
module tb_controller;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        br_eq;
  logic        br_lt;
  logic        pc_sel;
  logic [2:0]  imm_sel;
  logic        rf_we;
  logic        br_un;
  logic        a_sel;
  logic        b_sel;
  logic [3:0]  alu_sel;
  logic [3:0]  dmem_wbe;
  logic [2:0]  ld_sel;
  logic [1:0]  wb_sel;
  logic        illegal;

  int total = 0;
  int bad   = 0;
  logic exp_illegal = 1'b0;

  controller #(.DWIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .br_eq    (br_eq),
    .br_lt    (br_lt),
    .pc_sel   (pc_sel),
    .imm_sel  (imm_sel),
    .rf_we    (rf_we),
    .br_un    (br_un),
    .a_sel    (a_sel),
    .b_sel    (b_sel),
    .alu_sel  (alu_sel),
    .dmem_wbe (dmem_wbe),
    .ld_sel   (ld_sel),
    .wb_sel   (wb_sel),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] observed();
    return {pc_sel, imm_sel, rf_we, br_un, a_sel, b_sel, alu_sel, dmem_wbe, ld_sel, wb_sel};
  endfunction

  function automatic logic is_legal(input logic [31:0] ins);
    logic [6:0] legal_ops [11];
    legal_ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h33, 7'h13, 7'h0f, 7'h73};
    foreach (legal_ops[i]) if (ins[6:0] == legal_ops[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Reference decode written from the instruction-set rules (mnemonic level).
  function automatic logic [20:0] model(input logic [31:0] ins, input logic eq, input logic lt, input logic r);
    logic       pc, rf, bu, a, b;
    logic [2:0] imm, ld;
    logic [3:0] alu, wbe;
    logic [1:0] wb;
    logic [2:0] f3;
    logic [3:0] op_alu [8];
    f3 = ins[14:12];
    op_alu = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    pc = 0; rf = 0; bu = 0; a = 0; b = 1; imm = 0; ld = f3; alu = 0; wbe = 0; wb = 1;
    case (ins[6:0])
      7'h37: begin imm = 3; alu = 10; rf = 1; end
      7'h17: begin imm = 3; a = 1; rf = 1; end
      7'h6f: begin imm = 4; a = 1; pc = 1; rf = 1; wb = 2; end
      7'h67: begin pc = 1; rf = 1; wb = 2; end
      7'h63: begin
        imm = 2; a = 1; bu = f3[1];
        if (f3 == 0) pc = eq;
        else if (f3 == 1) pc = !eq;
        else if (f3 == 4 || f3 == 6) pc = lt;
        else if (f3 == 5 || f3 == 7) pc = !lt;
      end
      7'h03: begin rf = 1; wb = 0; end
      7'h23: begin imm = 1; wbe = (f3 == 0) ? 4'h1 : (f3 == 1) ? 4'h3 : (f3 == 2) ? 4'hf : 4'h0; end
      7'h33: begin
        b = 0; rf = 1; alu = op_alu[f3];
        if (ins[30] && f3 == 0) alu = 1;
        if (ins[30] && f3 == 5) alu = 7;
      end
      7'h13: begin
        rf = 1; alu = op_alu[f3];
        if (ins[30] && f3 == 5) alu = 7;
      end
      default: ;
    endcase
    if (r) begin pc = 0; rf = 0; wbe = 0; end
    return {pc, imm, rf, bu, a, b, alu, wbe, ld, wb};
  endfunction

  task automatic step(input logic [31:0] ins, input logic eq, input logic lt, input string name);
    logic [20:0] exp_v;
    logic [20:0] got_v;
    @(negedge clk);
    instr = ins; br_eq = eq; br_lt = lt;
    #1;
    exp_v = model(ins, eq, lt, 1'b0);
    got_v = observed();
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s decode instr=%08h eq=%0b lt=%0b got=%06h want=%06h", name, ins, eq, lt, got_v, exp_v);
    end
    @(posedge clk);
`ifdef CTRL_ILLEGAL_STICKY_EN
    exp_illegal = exp_illegal | !is_legal(ins);
`else
    exp_illegal = !is_legal(ins);
`endif
    #1;
    total++;
    if (illegal !== exp_illegal) begin
      bad++;
      $display("FAIL %s illegal instr=%08h got=%0b want=%0b", name, ins, illegal, exp_illegal);
    end
    $display("txn %-8s instr=%08h eq=%0b lt=%0b ctrl=%06h illegal=%0b", name, ins, eq, lt, got_v, illegal);
  endtask

  task automatic test_reset();
    instr = 32'h1000016f; br_eq = 0; br_lt = 0;
    #1;
    total++;
    if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%0b want=0", illegal); end
    total++;
    if (observed() !== model(instr, 0, 0, 1'b1)) begin
      bad++; $display("FAIL reset_gating got=%06h want=%06h", observed(), model(instr, 0, 0, 1'b1));
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    exp_illegal = 1'b0;
    $display("txn reset    released");
  endtask

  task automatic test_directed();
    step(32'h010000b7, 0, 0, "lui");
    step(32'h1000016f, 0, 0, "jal");
    step(32'h002101e7, 0, 0, "jalr");
    step(32'h00208263, 1, 0, "beq_t");
    step(32'h00208263, 0, 0, "beq_nt");
    step(32'h0020e263, 0, 1, "bltu_t");
    step(32'h0020e263, 0, 0, "bltu_nt");
    step(32'h0020f263, 0, 1, "bgeu_nt");
    step(32'h0020f263, 0, 0, "bgeu_t");
    step(32'h0020a263, 1, 1, "bad_f3");
    step(32'h00112223, 0, 0, "sw");
    step(32'h00110223, 0, 0, "sb");
    step(32'h00111223, 0, 0, "sh");
    step(32'h00412083, 0, 0, "lw");
    step(32'h403100b3, 0, 0, "sub");
    step(32'h40215093, 0, 0, "srai");
    step(32'h40010093, 0, 0, "addi30");
    step(32'h0000000f, 0, 0, "fence");
    step(32'h00000073, 0, 0, "ecall");
  endtask

  task automatic test_illegal();
    step(32'h00000000, 0, 0, "ill0");
    step(32'h010000b7, 0, 0, "after");
    step(32'h00000033, 0, 0, "add0");
  endtask

  task automatic test_reset_mid();
    step(32'h0000007f, 0, 0, "ill7f");
    @(negedge clk);
    #2;
    instr = 32'h00112223;
    rst = 1'b1;
    #1;
    exp_illegal = 1'b0;
    total++;
    if (illegal !== 1'b0) begin bad++; $display("FAIL mid_reset_illegal got=%0b want=0", illegal); end
    total++;
    if (rf_we !== 1'b0 || dmem_wbe !== 4'h0 || pc_sel !== 1'b0) begin
      bad++; $display("FAIL mid_reset_gating rf_we=%0b wbe=%h pc_sel=%0b want 0/0/0", rf_we, dmem_wbe, pc_sel);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("txn reset    mid-cycle pulse");
    step(32'h1000016f, 0, 0, "jal_post");
  endtask

  task automatic test_random();
    logic [6:0]  ops [11];
    logic [31:0] ins;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h33, 7'h13, 7'h0f, 7'h73};
    for (int n = 0; n < 150; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 9) != 0) ins[6:0] = ops[$urandom_range(0, 10)];
      step(ins, 1'($urandom), 1'($urandom), "random");
    end
  endtask

  initial begin
    rst = 1'b1;
    instr = '0; br_eq = 0; br_lt = 0;
    test_reset();
    test_directed();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
